// File: rtl/cnn_layer_accel_pkg.sv
// Shared definitions for the CNN layer accelerator blocks.
package cnn_layer_accel_pkg;

  localparam int C_NUM_ROW_BUF_DEFAULT = 4;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    WAIT_BUF,
    DONE
  } loaderState_e;

endpackage

// File: rtl/cnn_layer_accel_pixel_loader.sv
// Pixel loader: streams column words into a ring of row buffers and stalls
// upstream while every row buffer is still held by the consumer.
module cnn_layer_accel_pixel_loader
  import cnn_layer_accel_pkg::*;
#(
  parameter int C_PIXEL_WORD_WIDTH = 128,
  parameter int C_NUM_ROW_BUF      = C_NUM_ROW_BUF_DEFAULT,
  parameter int C_CFG_WIDTH        = 10,
  localparam int BUF_W  = (C_NUM_ROW_BUF > 1) ? $clog2(C_NUM_ROW_BUF) : 1,
  localparam int FREE_W = $clog2(C_NUM_ROW_BUF + 1)
) (
  input  logic                          clk_core,
  input  logic                          rst,
  input  logic                          start,
  input  logic [C_CFG_WIDTH-1:0]        num_input_cols_cfg,
  input  logic [C_CFG_WIDTH-1:0]        num_input_rows_cfg,
  input  logic                          pixel_valid,
  output logic                          pixel_ready,
  input  logic [C_PIXEL_WORD_WIDTH-1:0] pixel_data,
  output logic                          wr_en,
  output logic [BUF_W-1:0]              wr_buf_sel,
  output logic [C_CFG_WIDTH-1:0]        wr_addr,
  output logic [C_PIXEL_WORD_WIDTH-1:0] wr_data,
  output logic                          row_done,
  output logic [C_CFG_WIDTH-1:0]        row_done_idx,
  input  logic                          row_release,
  output logic                          busy,
  output logic                          frame_done
);

  localparam logic [FREE_W-1:0]      FREE_FULL = FREE_W'(C_NUM_ROW_BUF);
  localparam logic [C_CFG_WIDTH-1:0] CFG_ONE   = C_CFG_WIDTH'(1);
  localparam logic [BUF_W-1:0]       BUF_LAST  = BUF_W'(C_NUM_ROW_BUF - 1);

  loaderState_e                  state_q;
  logic [C_CFG_WIDTH-1:0]        numCols_q, numRows_q, col_q, row_q;
  logic [BUF_W-1:0]              bufPtr_q, bufPtr_d;
  logic [FREE_W-1:0]             freeCnt_q, freeCnt_d;
  logic                          wrEn_q, rowDone_q, frameDone_q;
  logic [BUF_W-1:0]              wrBufSel_q;
  logic [C_CFG_WIDTH-1:0]        wrAddr_q, rowDoneIdx_q;
  logic [C_PIXEL_WORD_WIDTH-1:0] wrData_q;
  logic                          xfer, rowEnd, lastRow, relAccept;

  assign pixel_ready = (state_q == LOAD) && (freeCnt_q != '0);
  assign xfer        = pixel_valid && pixel_ready;
  assign rowEnd      = xfer && (col_q == numCols_q - CFG_ONE);
  assign lastRow     = (row_q == numRows_q - CFG_ONE);
  assign relAccept   = row_release && (freeCnt_q != FREE_FULL);

  // A release landing on the same edge as a row completion cancels out.
  always_comb begin
    freeCnt_d = freeCnt_q;
    if (rowEnd && !row_release) begin
      freeCnt_d = freeCnt_q - FREE_W'(1);
    end else if (!rowEnd && relAccept) begin
      freeCnt_d = freeCnt_q + FREE_W'(1);
    end
    bufPtr_d = (bufPtr_q == BUF_LAST) ? '0 : bufPtr_q + BUF_W'(1);
  end

  always_ff @(posedge clk_core) begin
    if (rst) begin
      state_q      <= IDLE;
      numCols_q    <= '0;
      numRows_q    <= '0;
      col_q        <= '0;
      row_q        <= '0;
      bufPtr_q     <= '0;
      freeCnt_q    <= FREE_FULL;
      wrEn_q       <= 1'b0;
      wrBufSel_q   <= '0;
      wrAddr_q     <= '0;
      wrData_q     <= '0;
      rowDone_q    <= 1'b0;
      rowDoneIdx_q <= '0;
      frameDone_q  <= 1'b0;
    end else begin
      wrEn_q      <= xfer;
      rowDone_q   <= rowEnd;
      frameDone_q <= 1'b0;
      freeCnt_q   <= freeCnt_d;
      if (xfer) begin
        wrAddr_q   <= col_q;
        wrBufSel_q <= bufPtr_q;
        wrData_q   <= pixel_data;
        col_q      <= rowEnd ? '0 : col_q + CFG_ONE;
      end
      if (rowEnd) begin
        rowDoneIdx_q <= row_q;
        row_q        <= row_q + CFG_ONE;
        bufPtr_q     <= bufPtr_d;
      end
      case (state_q)
        IDLE: begin
          if (start) begin
            numCols_q <= num_input_cols_cfg;
            numRows_q <= num_input_rows_cfg;
            col_q     <= '0;
            row_q     <= '0;
            bufPtr_q  <= '0;
            freeCnt_q <= FREE_FULL;
            state_q   <= ((num_input_cols_cfg == '0) || (num_input_rows_cfg == '0)) ? DONE : LOAD;
          end
        end
        LOAD: begin
          if (rowEnd) begin
            if (lastRow) begin
              state_q <= DONE;
            end else if (freeCnt_d == '0) begin
              state_q <= WAIT_BUF;
            end
          end
        end
        WAIT_BUF: begin
          if (row_release) begin
            state_q <= LOAD;
          end
        end
        DONE: begin
          frameDone_q <= 1'b1;
          state_q     <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign wr_en        = wrEn_q;
  assign wr_buf_sel   = wrBufSel_q;
  assign wr_addr      = wrAddr_q;
  assign wr_data      = wrData_q;
  assign row_done     = rowDone_q;
  assign row_done_idx = rowDoneIdx_q;
  assign frame_done   = frameDone_q;
  assign busy         = (state_q != IDLE);

endmodule

// File: tb/tb_cnn_layer_accel_pixel_loader.sv
// Scoreboard bench for the pixel loader: drivers queue the expected write
// beats, a negedge monitor pops and compares every wr_en beat.
module tb_cnn_layer_accel_pixel_loader;

  localparam int W    = 128;
  localparam int NBUF = 4;
  localparam int CW   = 10;

  typedef struct packed {
    logic [1:0]    bufSel;
    logic [CW-1:0] addr;
    logic [W-1:0]  data;
    logic          rowDone;
    logic [CW-1:0] rowIdx;
  } wrRec_t;

  logic          clk_core = 1'b0;
  logic          rst, start, pixel_valid, pixel_ready, wr_en, row_done, busy, frame_done;
  logic          row_release;
  logic [CW-1:0] num_input_cols_cfg, num_input_rows_cfg, wr_addr, row_done_idx;
  logic [W-1:0]  pixel_data, wr_data;
  logic [1:0]    wr_buf_sel;
  logic          relMain = 1'b0;
  logic          relAuto = 1'b0;
  logic          autoRelease = 1'b0;

  int testsRun = 0;
  int failCount = 0;
  int writeCount = 0;
  int rowDoneCount = 0;
  int frameDoneCount = 0;
  int cycle = 0;
  int lastWriteCycle = 0;
  int frameDoneCycle = 0;
  int startCycle = 0;
  wrRec_t expQ[$];
  wrRec_t monAct, monExp;

  always #5 clk_core = ~clk_core;
  always @(posedge clk_core) cycle <= cycle + 1;
  assign row_release = relMain | relAuto;

  cnn_layer_accel_pixel_loader dut (
    .clk_core           (clk_core),
    .rst                (rst),
    .start              (start),
    .num_input_cols_cfg (num_input_cols_cfg),
    .num_input_rows_cfg (num_input_rows_cfg),
    .pixel_valid        (pixel_valid),
    .pixel_ready        (pixel_ready),
    .pixel_data         (pixel_data),
    .wr_en              (wr_en),
    .wr_buf_sel         (wr_buf_sel),
    .wr_addr            (wr_addr),
    .wr_data            (wr_data),
    .row_done           (row_done),
    .row_done_idx       (row_done_idx),
    .row_release        (row_release),
    .busy               (busy),
    .frame_done         (frame_done)
  );

  task automatic checkOutput(input string name, input logic [159:0] actual, input logic [159:0] expected);
    testsRun++;
    if (actual !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: actual %0h required %0h", name, actual, expected);
    end
  endtask

  task automatic checkCount(input string name, input int actual, input int expected);
    testsRun++;
    if (actual != expected) begin
      failCount++;
      $display("[TB] FAIL %s: actual %0d required %0d", name, actual, expected);
    end
  endtask

  function automatic logic [W-1:0] wordData(input int idx);
    return {16'hC0DE, 48'h0, 32'(idx * 7 + 1), 32'(idx)};
  endfunction

  task automatic pushExpect(input int idx, input int cols);
    wrRec_t r;
    int row = idx / cols;
    int col = idx % cols;
    r.bufSel  = 2'(row % NBUF);
    r.addr    = CW'(col);
    r.data    = wordData(idx);
    r.rowDone = (col == cols - 1);
    r.rowIdx  = r.rowDone ? CW'(row) : '0;
    expQ.push_back(r);
  endtask

  // Every wr_en beat must match the oldest queued expectation.
  always @(negedge clk_core) begin
    relAuto = autoRelease && row_done;
    if (wr_en) begin
      writeCount++;
      lastWriteCycle = cycle;
      if (row_done) rowDoneCount++;
      monAct.bufSel  = wr_buf_sel;
      monAct.addr    = wr_addr;
      monAct.data    = wr_data;
      monAct.rowDone = row_done;
      monAct.rowIdx  = row_done ? row_done_idx : '0;
      checkCount("write_expected", int'(expQ.size() != 0), 1);
      if (expQ.size() != 0) begin
        monExp = expQ.pop_front();
        checkOutput("write_beat", 160'(monAct), 160'(monExp));
      end
    end else if (row_done) begin
      checkCount("row_done_without_wr_en", int'(wr_en), 1);
    end
    if (frame_done) begin
      frameDoneCount++;
      frameDoneCycle = cycle;
    end
  end

  task automatic clearCounts();
    writeCount = 0;
    rowDoneCount = 0;
    frameDoneCount = 0;
  endtask

  task automatic applyStart(input int cols, input int rows);
    num_input_cols_cfg = CW'(cols);
    num_input_rows_cfg = CW'(rows);
    start = 1'b1;
    startCycle = cycle;
    @(negedge clk_core);
    start = 1'b0;
  endtask

  task automatic applyStimulus(input int idx, input int cols, input int gap, input bit withRel);
    int waitCnt = 0;
    if (gap > 0) begin
      pixel_valid = 1'b0;
      repeat (gap) @(negedge clk_core);
    end
    pushExpect(idx, cols);
    pixel_valid = 1'b1;
    pixel_data  = wordData(idx);
    while (!pixel_ready && waitCnt < 200) begin
      @(negedge clk_core);
      waitCnt++;
    end
    if (!pixel_ready) begin
      checkCount("pixel_ready_timeout", int'(pixel_ready), 1);
      void'(expQ.pop_back());
      pixel_valid = 1'b0;
      return;
    end
    relMain = withRel;
    @(negedge clk_core);
    relMain = 1'b0;
  endtask

  task automatic waitFrame(input string name, input int budget);
    int n = 0;
    while (frameDoneCount == 0 && n < budget) begin
      @(negedge clk_core);
      n++;
    end
    checkCount({name, "_frame_done_seen"}, int'(frameDoneCount != 0), 1);
    repeat (2) @(negedge clk_core);
    checkCount({name, "_frame_done_pulses"}, frameDoneCount, 1);
    checkCount({name, "_idle_after_frame"}, int'({busy, pixel_ready}), 0);
    checkCount({name, "_queue_empty"}, expQ.size(), 0);
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst = 1'b1;
    start = 1'b0;
    pixel_valid = 1'b0;
    pixel_data = '0;
    num_input_cols_cfg = '0;
    num_input_rows_cfg = '0;
    repeat (3) @(negedge clk_core);
    checkOutput("reset_outputs", 160'({pixel_ready, wr_en, wr_buf_sel, wr_addr, wr_data,
                row_done, row_done_idx, busy, frame_done}), '0);
    rst = 1'b0;
    @(negedge clk_core);
    checkCount("idle_after_reset", int'({busy, pixel_ready, wr_en}), 0);

    // 4x2 frame, valid held high, no releases needed.
    clearCounts();
    applyStart(4, 2);
    checkCount("t1_busy", int'(busy), 1);
    for (int i = 0; i < 8; i++) applyStimulus(i, 4, 0, 1'b0);
    pixel_valid = 1'b0;
    waitFrame("t1", 20);
    checkCount("t1_writes", writeCount, 8);
    checkCount("t1_row_dones", rowDoneCount, 2);
    checkCount("t1_frame_after_last_write", frameDoneCycle - lastWriteCycle, 1);

    // 3x6 frame: a release while all buffers are free is ignored, so the
    // loader stalls after four rows until one buffer comes back.
    clearCounts();
    applyStart(3, 6);
    relMain = 1'b1;
    @(negedge clk_core);
    relMain = 1'b0;
    for (int i = 0; i < 12; i++) applyStimulus(i, 3, 0, 1'b0);
    pixel_valid = 1'b1;
    pixel_data  = wordData(12);
    repeat (4) @(negedge clk_core);
    checkCount("t2_stalled_ready", int'(pixel_ready), 0);
    checkCount("t2_stalled_busy", int'(busy), 1);
    checkCount("t2_writes_before_release", writeCount, 12);
    relMain = 1'b1;
    @(negedge clk_core);
    relMain = 1'b0;
    autoRelease = 1'b1;
    for (int i = 12; i < 18; i++) applyStimulus(i, 3, 0, 1'b0);
    pixel_valid = 1'b0;
    waitFrame("t2", 20);
    autoRelease = 1'b0;
    checkCount("t2_writes", writeCount, 18);
    checkCount("t2_row_dones", rowDoneCount, 6);

    // Release coinciding with a row completion at one free buffer.
    clearCounts();
    applyStart(2, 5);
    for (int i = 0; i < 7; i++) applyStimulus(i, 2, 0, 1'b0);
    applyStimulus(7, 2, 0, 1'b1);
    checkCount("t3_ready_after_coincident_release", int'(pixel_ready), 1);
    for (int i = 8; i < 10; i++) applyStimulus(i, 2, 0, 1'b0);
    pixel_valid = 1'b0;
    waitFrame("t3", 20);
    checkCount("t3_writes", writeCount, 10);
    checkCount("t3_row_dones", rowDoneCount, 5);

    // 25x25 frame with random valid gaps.
    clearCounts();
    autoRelease = 1'b1;
    applyStart(25, 25);
    for (int i = 0; i < 625; i++) applyStimulus(i, 25, int'($urandom_range(0, 2)), 1'b0);
    pixel_valid = 1'b0;
    waitFrame("t4", 100);
    checkCount("t4_writes", writeCount, 625);
    checkCount("t4_row_dones", rowDoneCount, 25);

    // Reset mid-frame, then a full fresh frame.
    clearCounts();
    applyStart(25, 25);
    for (int i = 0; i < 10; i++) applyStimulus(i, 25, 0, 1'b0);
    rst = 1'b1;
    @(negedge clk_core);
    checkOutput("t5_outputs_after_rst", 160'({pixel_ready, wr_en, wr_buf_sel, wr_addr, wr_data,
                row_done, row_done_idx, busy, frame_done}), '0);
    rst = 1'b0;
    pixel_valid = 1'b0;
    repeat (3) @(negedge clk_core);
    checkCount("t5_writes_before_abort", writeCount, 10);
    checkCount("t5_no_frame_done_on_abort", frameDoneCount, 0);
    checkCount("t5_queue_empty_after_abort", expQ.size(), 0);
    clearCounts();
    applyStart(25, 25);
    for (int i = 0; i < 625; i++) applyStimulus(i, 25, 0, 1'b0);
    pixel_valid = 1'b0;
    waitFrame("t5", 100);
    autoRelease = 1'b0;
    checkCount("t5_writes", writeCount, 625);
    checkCount("t5_row_dones", rowDoneCount, 25);

    // Empty frame, then a start pulse during LOAD that must be ignored.
    clearCounts();
    applyStart(5, 0);
    waitFrame("t6a", 10);
    checkCount("t6a_frame_done_latency", frameDoneCycle - startCycle, 2);
    checkCount("t6a_writes", writeCount, 0);
    clearCounts();
    applyStart(3, 2);
    for (int i = 0; i < 2; i++) applyStimulus(i, 3, 0, 1'b0);
    pixel_valid = 1'b0;
    applyStart(7, 1);
    for (int i = 2; i < 6; i++) applyStimulus(i, 3, 0, 1'b0);
    pixel_valid = 1'b0;
    waitFrame("t6b", 20);
    checkCount("t6b_writes", writeCount, 6);
    checkCount("t6b_row_dones", rowDoneCount, 2);

    $display("[TB] %0d tests run, %0d failed", testsRun, failCount);
    $finish;
  end

endmodule

// File: doc/cnn_layer_accel_pixel_loader.md
CNN_LAYER_ACCEL_PIXEL_LOADER -- requirements
Module: cnn_layer_accel_pixel_loader

Interface
REQ-001 SHALL have parameter C_PIXEL_WORD_WIDTH, default 128: width of one input word, one column of pixels across NUM_CE_PER_AWE depth slices.
REQ-002 SHALL have parameter C_NUM_ROW_BUF, default 4: number of circular row buffers fed.
REQ-003 SHALL have parameter C_CFG_WIDTH, default 10: width of row, column and address counters.
REQ-004 SHALL have port clk_core, input, 1: the only clock; all logic is rising-edge.
REQ-005 SHALL have port rst, input, 1: synchronous, active-high reset.
REQ-006 SHALL have port start, input, 1: one-cycle job start pulse.
REQ-007 SHALL have port num_input_cols_cfg, input, C_CFG_WIDTH: columns per row; sampled on start.
REQ-008 SHALL have port num_input_rows_cfg, input, C_CFG_WIDTH: rows per frame; sampled on start.
REQ-009 SHALL have port pixel_valid, input, 1: upstream word valid.
REQ-010 SHALL have port pixel_ready, output, 1: loader accepts a word.
REQ-011 SHALL have port pixel_data, input, C_PIXEL_WORD_WIDTH: upstream word.
REQ-012 SHALL have port wr_en, output, 1: row buffer write strobe.
REQ-013 SHALL have port wr_buf_sel, output, clog2(C_NUM_ROW_BUF): target row buffer.
REQ-014 SHALL have port wr_addr, output, C_CFG_WIDTH: column address.
REQ-015 SHALL have port wr_data, output, C_PIXEL_WORD_WIDTH: registered copy of pixel_data.
REQ-016 SHALL have port row_done, output, 1: pulse, row completely written.
REQ-017 SHALL have port row_done_idx, output, C_CFG_WIDTH: input row index of the completed row.
REQ-018 SHALL have port row_release, input, 1: pulse from the row buffer consumer freeing one buffer.
REQ-019 SHALL have port busy, output, 1: job in progress.
REQ-020 SHALL have port frame_done, output, 1: pulse, last row of the frame written.

Function
REQ-021 SHALL implement states IDLE, LOAD, WAIT_BUF, DONE.
REQ-022 IDLE: start SHALL latch cfg, clear counters, set free_cnt=C_NUM_ROW_BUF and go to LOAD; start in any other state SHALL be ignored.
REQ-023 Start with cols==0 or rows==0 SHALL go directly to DONE with no writes.
REQ-024 pixel_ready SHALL be 1 only in LOAD with free_cnt>0; a transfer occurs when pixel_valid and pixel_ready are both 1.
REQ-025 Each transfer SHALL produce, on the next cycle, wr_en=1, wr_addr=col, wr_buf_sel=buf_ptr and wr_data=pixel_data (1-cycle latency).
REQ-026 col SHALL increment per transfer; at col==cols-1 it SHALL wrap to 0, row SHALL increment, buf_ptr SHALL advance modulo C_NUM_ROW_BUF and free_cnt SHALL decrement.
REQ-027 row_done SHALL be asserted in the same cycle as the wr_en of the row's last column, with row_done_idx equal to that row's index.
REQ-028 A row_release in the same cycle as a row completion SHALL leave free_cnt unchanged; row_release with free_cnt==C_NUM_ROW_BUF SHALL be ignored (saturate).
REQ-029 LOAD SHALL go to WAIT_BUF when a row completes, free_cnt becomes 0, and rows remain; WAIT_BUF SHALL return to LOAD on row_release.
REQ-030 Completion of row rows-1 SHALL go to DONE; DONE SHALL pulse frame_done for one cycle and go to IDLE.
REQ-031 busy SHALL be 1 in LOAD, WAIT_BUF and DONE.
REQ-032 Cleared counters and bits (wr_en, row_done, frame_done) SHALL be 0 in every cycle with no event.

Reset
REQ-033 rst SHALL force IDLE and set pixel_ready, wr_en, wr_buf_sel, wr_addr, wr_data, row_done, row_done_idx, busy and frame_done to 0, with free_cnt=C_NUM_ROW_BUF.
REQ-034 rst mid-frame SHALL abort the frame with no further writes or pulses; rst has priority over start.

Structure
REQ-035 The state enum and C_NUM_ROW_BUF default SHALL live in the shared cnn_layer_accel package / defs header.
REQ-036 The block SHALL be a single module with no sub-modules; the row-buffer free counter is inline logic.

Verification
REQ-037 cols=4, rows=2, valid held high, release never -> 8 writes, addr 0..3 on buf 0 then buf 1, row_done at writes 4 and 8 with idx 0 and 1, frame_done 1 cycle after the last write.
REQ-038 cols=3, rows=6, no release -> pixel_ready drops after 4 rows (12 words), state WAIT_BUF; one row_release -> row 4 written to buf 0.
REQ-039 Simultaneous row_release and row completion at free_cnt=1 -> free_cnt stays 1 and pixel_ready stays 1.
REQ-040 Random pixel_valid gaps, cols=25, rows=25 -> wr_data matches input order, exactly 625 writes, 25 row_done pulses.
REQ-041 rst asserted at word 10 of a 25x25 frame -> all outputs 0 next cycle; new start then runs a full frame from addr 0, buf 0.
REQ-042 start with rows=0 -> no wr_en, frame_done 2 cycles after start; start pulsed during LOAD -> ignored, counts unchanged.
